half_adder_reg: RTL and testbench
=================================

// Module: half_adder_reg
// PURPOSE
//  - Registered, lane-parallel half adder: per lane sum = a ^ b, carry = a & b.
//  - Outputs are captured on the clock with a valid qualifier.
//  - Leaf arithmetic primitive; upstream datapath logic feeds it, and
//    ripple/compressor logic downstream consumes sum/carry pairs.
//  - LANES=1 gives the classic scalar half adder with ports a, b, sum, carry.
// PARAMETERS
//  - LANES   default 1   number of independent 1-bit half-adder lanes (>=1)
//  - CNT_W   default 16  width of carry-event counter (used only with HALF_ADDER_STATS_EN)
// PORTS
//  - clk          in   1      single clock; all state updates on rising edge
//  - rst_n        in   1      synchronous reset, active-low
//  - in_valid     in   1      a/b are valid this cycle
//  - a            in   LANES  addend A, one bit per lane
//  - b            in   LANES  addend B, one bit per lane
//  - out_valid    out  1      sum/carry hold a newly computed result
//  - sum          out  LANES  per-lane a ^ b (registered)
//  - carry        out  LANES  per-lane a & b (registered)
//  - carry_count  out  CNT_W  saturating count of lanes producing carry (STATS_EN only)
// BEHAVIOUR
//  - Clocking and reset: one clock; reset is synchronous and active-low.
//    rst_n is sampled only at the rising edge of clk.
//  - Reset values: out_valid=0, sum=0, carry=0, carry_count=0.
//  - Reset dominates in_valid in the same cycle.
//  - Latency is exactly 1 cycle: a result presented with in_valid=1 at edge N
//    appears on sum/carry with out_valid=1 after edge N.
//  - Update rule: when in_valid=1, sum <= a ^ b and carry <= a & b for every lane.
//  - When in_valid=0, sum and carry hold their previous values and out_valid <= 0.
//  - out_valid <= in_valid each cycle, so a 1-cycle pulse follows each accepted input.
//  - No backpressure: every valid input is accepted with no stall.
//    Back-to-back in_valid gives back-to-back results.
//  - Lanes are fully independent; there is no carry propagation between lanes.
//  - Truth table per lane (a,b -> sum,carry): 00->0,0  01->1,0  10->1,0  11->0,1.
//  - sum and carry are never both 1 in the same lane.
//  - Reset mid-stream: a result in flight is discarded.
//    The cycle after reset deasserts shows out_valid=0 and sum=carry=0.
//  - X on a/b while in_valid=0 must not change the outputs.
// CONFIGURATION
//  - Macro HALF_ADDER_STATS_EN.
//  - Defined: carry_count exists.
//    On each accepted input (in_valid=1) it adds popcount(a & b).
//    It saturates at 2**CNT_W-1 and never wraps. Reset clears it to 0.
//  - Undefined: the carry_count port and counter logic are absent, and all
//    other behaviour is unchanged.
// STRUCTURE
//  - Package half_adder_pkg holds:
//    - DEFAULT_LANES = 1 and DEFAULT_CNT_W = 16 constants;
//    - function popcount for the stats counter;
//    - typedef ha_result_t {sum, carry}, a 2-bit struct per lane.
//  - Sub-module half_adder_cell: purely combinational 1-lane cell (a,b -> sum,carry).
//    It is instantiated LANES times in a generate loop.
//  - Top level holds the output registers, the valid register and the optional counter.
// TESTING
//  - Exhaustive LANES=1, 1 ns per vector: (a,b) = 00, 01, 10, 11 with in_valid=1.
//    Required (sum,carry) one cycle later: 00, 10, 10, 01; out_valid=1 each cycle.
//  - Hold: load a=1, b=1, then drive in_valid=0 with a=0, b=1.
//    Required: sum=0, carry=1 retained; out_valid drops to 0.
//  - Reset mid-op: in_valid=1, a=1, b=0, with rst_n=0 at the same edge.
//    Required: sum=0, carry=0, out_valid=0 next cycle.
//  - Multi-lane LANES=4: a=4'b1100, b=4'b1010.
//    Required: sum=4'b0110, carry=4'b1000.
//  - STATS_EN with CNT_W=2, LANES=4: four cycles of a=b=4'hF.
//    Required: carry_count goes 3, then stays 3 (saturated).

Source files
------------

// File: rtl/half_adder_pkg.sv
// Shared constants, per-lane result type and popcount helper for half_adder_reg.
`timescale 1ns/1ps
package half_adder_pkg;

  localparam int DEFAULT_LANES = 1;
  localparam int DEFAULT_CNT_W = 16;
  // Widest lane vector popcount accepts; narrower vectors are zero-padded.
  localparam int MAX_LANES     = 256;

  typedef struct packed {
    logic sum;
    logic carry;
  } ha_result_t;

  function automatic int unsigned popcount(input logic [MAX_LANES-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Combinational single-lane half adder: sum = a ^ b, carry = a & b.
`timescale 1ns/1ps
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/half_adder_reg.sv
// Registered lane-parallel half adder with valid qualifier.
// Optional saturating carry-event counter enabled by macro HALF_ADDER_STATS_EN.
`timescale 1ns/1ps
module half_adder_reg
  import half_adder_pkg::*;
#(
  parameter int LANES = DEFAULT_LANES,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  output logic             out_valid,
  output logic [LANES-1:0] sum,
  output logic [LANES-1:0] carry
`ifdef HALF_ADDER_STATS_EN
  ,
  output logic [CNT_W-1:0] carry_count
`endif
);

  if (LANES < 1 || LANES > MAX_LANES || CNT_W < 1) begin : g_bad_params
    $error("half_adder_reg: LANES must be 1..%0d and CNT_W >= 1", MAX_LANES);
  end

  ha_result_t [LANES-1:0] cell_res;
  logic [LANES-1:0]       sum_next, carry_next;
  logic [LANES-1:0]       sum_reg, carry_reg;
  logic                   valid_reg;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    half_adder_cell u_cell (
      .a     (a[gi]),
      .b     (b[gi]),
      .sum   (cell_res[gi].sum),
      .carry (cell_res[gi].carry)
    );
    assign sum_next[gi]   = cell_res[gi].sum;
    assign carry_next[gi] = cell_res[gi].carry;
  end

  // Result registers only load on accepted input, so idle-cycle a/b (even X) never leak out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      sum_reg   <= '0;
      carry_reg <= '0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg   <= sum_next;
        carry_reg <= carry_next;
      end
    end
  end

  assign out_valid = valid_reg;
  assign sum       = sum_reg;
  assign carry     = carry_reg;

`ifdef HALF_ADDER_STATS_EN
  // Accumulator is wide enough to hold count + LANES without overflow before saturating.
  localparam int ACC_W = CNT_W + 10;

  logic [CNT_W-1:0]     count_reg, count_next;
  logic [MAX_LANES-1:0] carry_vec;
  logic [ACC_W-1:0]     acc;

  always_comb begin
    carry_vec              = '0;
    carry_vec[LANES-1:0]   = carry_next;
    acc                    = ACC_W'(count_reg) + ACC_W'(popcount(carry_vec));
    count_next             = (acc > ACC_W'({CNT_W{1'b1}})) ? '1 : acc[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (in_valid) begin
      count_reg <= count_next;
    end
  end

  assign carry_count = count_reg;
`endif

endmodule

// File: tb/tb_half_adder_reg.sv
// Self-checking bench for half_adder_reg: scalar and 4-lane instances, directed and random.
`timescale 1ns/1ps
module tb_half_adder_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [0:0] a1, b1;
  logic [3:0] a4, b4;
  logic       ov1, ov4;
  logic [0:0] s1, c1;
  logic [3:0] s4, c4;
`ifdef HALF_ADDER_STATS_EN
  logic [15:0] cc1;
  logic [1:0]  cc4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: expected outputs after the most recent edge.
  logic       e_v;
  logic [0:0] e_s1, e_c1;
  logic [3:0] e_s4, e_c4;
  int         e_cnt1, e_cnt4;

  always #0.5 clk = ~clk;

  half_adder_reg #(.LANES(1), .CNT_W(16)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a1),
    .b         (b1),
    .out_valid (ov1),
    .sum       (s1),
    .carry     (c1)
`ifdef HALF_ADDER_STATS_EN
    ,
    .carry_count (cc1)
`endif
  );

  half_adder_reg #(.LANES(4), .CNT_W(2)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a4),
    .b         (b4),
    .out_valid (ov4),
    .sum       (s4),
    .carry     (c4)
`ifdef HALF_ADDER_STATS_EN
    ,
    .carry_count (cc4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-lane arithmetic: a+b gives a 2-bit value whose low bit is sum and high bit is carry.
  task automatic model_edge();
    int t, hits;
    if (!rst_n) begin
      e_v = 0; e_s1 = 0; e_c1 = 0; e_s4 = 0; e_c4 = 0; e_cnt1 = 0; e_cnt4 = 0;
    end else begin
      e_v = in_valid;
      if (in_valid) begin
        t = int'(a1[0]) + int'(b1[0]);
        e_s1[0] = (t % 2) != 0;
        e_c1[0] = (t / 2) != 0;
        e_cnt1 = (e_cnt1 + t / 2 > 65535) ? 65535 : e_cnt1 + t / 2;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
          t = int'(a4[i]) + int'(b4[i]);
          e_s4[i] = (t % 2) != 0;
          e_c4[i] = (t / 2) != 0;
          hits += t / 2;
        end
        e_cnt4 = (e_cnt4 + hits > 3) ? 3 : e_cnt4 + hits;
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #0.2;
    chk({tag, ".v1"}, 32'(ov1), 32'(e_v));
    chk({tag, ".s1"}, 32'(s1),  32'(e_s1));
    chk({tag, ".c1"}, 32'(c1),  32'(e_c1));
    chk({tag, ".v4"}, 32'(ov4), 32'(e_v));
    chk({tag, ".s4"}, 32'(s4),  32'(e_s4));
    chk({tag, ".c4"}, 32'(c4),  32'(e_c4));
    chk({tag, ".excl"}, 32'(s4 & c4), 32'd0);
`ifdef HALF_ADDER_STATS_EN
    chk({tag, ".cnt1"}, 32'(cc1), 32'(e_cnt1));
    chk({tag, ".cnt4"}, 32'(cc4), 32'(e_cnt4));
`endif
    $display("txn %s: rst_n=%0b iv=%0b a1=%0b b1=%0b a4=%h b4=%h -> v=%0b s1=%0b c1=%0b s4=%h c4=%h",
             tag, rst_n, in_valid, a1, b1, a4, b4, ov4, s1, c1, s4, c4);
  endtask

  logic [1:0] vec;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a1 = '0; b1 = '0; a4 = '0; b4 = '0;
    cycle("rst0");
    cycle("rst1");
    chk("reset.valid", 32'(ov1), 32'd0);
    chk("reset.sum4",  32'(s4),  32'd0);
    rst_n = 1'b1;

    // Exhaustive scalar truth table, back-to-back.
    for (int i = 0; i < 4; i++) begin
      vec = 2'(i);
      in_valid = 1'b1; a1[0] = vec[1]; b1[0] = vec[0];
      cycle($sformatf("tt%0d", i));
      chk($sformatf("tt%0d.sc", i), 32'({s1, c1}),
          (i == 0) ? 32'b00 : (i == 3) ? 32'b01 : 32'b10);
      chk($sformatf("tt%0d.v", i), 32'(ov1), 32'd1);
    end

    // Hold: load 1+1, then idle with different operands (and X).
    a1 = 1'b1; b1 = 1'b1; in_valid = 1'b1;
    cycle("hold_load");
    in_valid = 1'b0; a1 = 1'b0; b1 = 1'b1;
    cycle("hold_idle");
    chk("hold.sum",   32'(s1),  32'd0);
    chk("hold.carry", 32'(c1),  32'd1);
    chk("hold.valid", 32'(ov1), 32'd0);
    a1 = 'x; b1 = 'x; a4 = 'x; b4 = 'x;
    cycle("hold_x");
    chk("holdx.carry", 32'(c1), 32'd1);

    // Reset dominates an input presented at the same edge.
    in_valid = 1'b1; a1 = 1'b1; b1 = 1'b0; a4 = 4'hF; b4 = 4'hF; rst_n = 1'b0;
    cycle("rst_mid");
    chk("rstmid.sc", 32'({ov1, s1, c1}), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    cycle("rst_after");

    // Multi-lane directed vector.
    in_valid = 1'b1; a4 = 4'b1100; b4 = 4'b1010; a1 = 1'b0; b1 = 1'b0;
    cycle("ml");
    chk("ml.sum",   32'(s4), 32'b0110);
    chk("ml.carry", 32'(c4), 32'b1000);

`ifdef HALF_ADDER_STATS_EN
    rst_n = 1'b0; in_valid = 1'b0;
    cycle("st_rst");
    rst_n = 1'b1; in_valid = 1'b1; a4 = 4'hF; b4 = 4'hF;
    for (int i = 0; i < 4; i++) begin
      cycle($sformatf("sat%0d", i));
      chk($sformatf("sat%0d.cnt", i), 32'(cc4), 32'd3);
    end
`endif

    // Random traffic with occasional reset.
    for (int i = 0; i < 200; i++) begin
      rst_n    = ($urandom_range(0, 19) != 0);
      in_valid = $urandom_range(0, 2) != 0;
      a1 = 1'($urandom); b1 = 1'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom);
      cycle($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
